// File: rtl/morse_key_receiver.sv
// Morse key receive path: synchronise, debounce, time presses/gaps, assemble one letter code.
// Optional word-gap detection is built when WORD_GAP_EN is defined.
module morse_key_receiver #(
    parameter int unsigned TICK_DIV         = 100000,
    parameter int unsigned DEBOUNCE_TICKS   = 20,
    parameter int unsigned DASH_TICKS       = 300,
    parameter int unsigned LETTER_GAP_TICKS = 600,
    parameter int unsigned WORD_GAP_TICKS   = 1400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_clean,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [2:0] sym_len,
    output logic [4:0] sym_bits,
    output logic       sym_err,
    output logic       overrun,
    output logic       word_space
);

    localparam int unsigned PRE_W    = $clog2(TICK_DIV + 1);
    localparam int unsigned DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned MAX_A    = (WORD_GAP_TICKS > LETTER_GAP_TICKS) ? WORD_GAP_TICKS : LETTER_GAP_TICKS;
    localparam int unsigned CNT_MAX  = (DASH_TICKS > MAX_A) ? DASH_TICKS : MAX_A;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic             key_meta;
    logic             key_sync;
    logic             key_prev;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [DEB_W-1:0] deb_cnt;

    state_t           state;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [4:0]       bits_acc;
    logic [2:0]       len_acc;
    logic             err_acc;

    logic             rise_c;
    logic             fall_c;
    logic [CNT_W-1:0] press_inc_c;
    logic [CNT_W-1:0] gap_inc_c;

    assign rise_c      = key_clean & ~key_prev;
    assign fall_c      = ~key_clean & key_prev;
    assign press_inc_c = (&press_cnt) ? press_cnt : press_cnt + CNT_W'(1);
    assign gap_inc_c   = (&gap_cnt) ? gap_cnt : gap_cnt + CNT_W'(1);

    // Synchroniser, tick prescaler and debounce filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            key_prev  <= 1'b0;
            key_clean <= 1'b0;
            pre_cnt   <= '0;
            tick      <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
            key_prev <= key_clean;

            if (pre_cnt == PRE_W'(TICK_DIV - 1)) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick    <= 1'b0;
            end

            if (key_sync == key_clean) begin
                deb_cnt <= '0;
            end else if (tick) begin
                if (deb_cnt + DEB_W'(1) == DEB_W'(DEBOUNCE_TICKS)) begin
                    key_clean <= key_sync;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end
        end
    end

`ifdef WORD_GAP_EN
    logic word_armed;
`endif

    // Element timing, letter assembly and single-entry output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            press_cnt <= '0;
            gap_cnt   <= '0;
            bits_acc  <= '0;
            len_acc   <= '0;
            err_acc   <= 1'b0;
            sym_valid <= 1'b0;
            sym_len   <= '0;
            sym_bits  <= '0;
            sym_err   <= 1'b0;
            overrun   <= 1'b0;
`ifdef WORD_GAP_EN
            word_space <= 1'b0;
            word_armed <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef WORD_GAP_EN
            word_space <= 1'b0;
`endif
            if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise_c) begin
                        state     <= PRESS;
                        press_cnt <= '0;
`ifdef WORD_GAP_EN
                        word_armed <= 1'b0;
                    end else if (word_armed && tick) begin
                        gap_cnt <= gap_inc_c;
                        if (gap_inc_c == CNT_W'(WORD_GAP_TICKS)) begin
                            word_space <= 1'b1;
                            word_armed <= 1'b0;
                        end
`endif
                    end
                end
                PRESS: begin
                    if (fall_c) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        // A sixth element flags the letter but leaves the first five intact.
                        if (len_acc == 3'd5) begin
                            err_acc <= 1'b1;
                        end else begin
                            bits_acc[len_acc] <= (press_cnt >= CNT_W'(DASH_TICKS));
                            len_acc           <= len_acc + 3'd1;
                        end
                    end else if (tick) begin
                        press_cnt <= press_inc_c;
                    end
                end
                GAP: begin
                    if (rise_c) begin
                        state     <= PRESS;
                        press_cnt <= '0;
                    end else if (tick) begin
                        gap_cnt <= gap_inc_c;
                        if (gap_inc_c == CNT_W'(LETTER_GAP_TICKS)) begin
                            state    <= IDLE;
                            bits_acc <= '0;
                            len_acc  <= '0;
                            err_acc  <= 1'b0;
`ifdef WORD_GAP_EN
                            word_armed <= 1'b1;
`endif
                            if (!sym_valid || sym_ready) begin
                                sym_bits  <= bits_acc;
                                sym_len   <= len_acc;
                                sym_err   <= err_acc;
                                sym_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef WORD_GAP_EN
    assign word_space = 1'b0;
`endif

endmodule
